montexp_seq: RTL and testbench

- Modular-exponentiation sequencer that acts as the initiator on the start/vld Montgomery-multiplier interface.
- Computes r = base^expo mod m with left-to-right square-and-multiply.
- Issues one multiply at a time to an external Montgomery multiplier (r = a*b*R^-1 mod m, R = 2^WID), including the conversions into and out of the Montgomery domain.
- Sits between the ECC/RSA control layer and the multiplier wrapper.

---
 rtl/montexp_seq.sv | 199 +++++++++++++++++++
 tb/tb_montexp_seq.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/montexp_seq.sv
// Modular-exponentiation sequencer: r = base^expo mod m using left-to-right
// square-and-multiply over an external Montgomery multiplier (a*b*R^-1 mod m).
// Optional build macro MONTEXP_SKIPLZ_EN skips squarings of leading zero
// exponent bits.
module montexp_seq #(
    parameter int unsigned WID   = 256,
    parameter int unsigned EWID  = 256,
    parameter int unsigned ECNTW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [WID-1:0]  base,
    input  logic [EWID-1:0] expo,
    input  logic [WID-1:0]  m,
    input  logic [WID-1:0]  r2,
    output logic            busy,
    output logic            vld,
    output logic [WID-1:0]  r,
    output logic            mul_start,
    output logic [WID-1:0]  mul_a,
    output logic [WID-1:0]  mul_b,
    output logic [WID-1:0]  mul_m,
    input  logic            mul_vld,
    input  logic [WID-1:0]  mul_r
);

    typedef enum logic [2:0] {
        StIdle, StToMont, StOne, StSqr, StMul, StStep, StFrom, StDone
    } state_e;

    localparam logic [WID-1:0]   One    = WID'(1);
    localparam logic [ECNTW-1:0] IdxTop = ECNTW'(EWID - 1);

    state_e            state_q, state_d;
    logic [WID-1:0]    base_q, base_d, m_q, m_d, r2_q, r2_d;
    logic [EWID-1:0]   expo_q, expo_d;
    logic [WID-1:0]    xbar_q, xbar_d, acc_q, acc_d, r_q, r_d;
    logic [ECNTW-1:0]  idx_q, idx_d;
    logic              wait_q, wait_d;
    logic              mul_start_q, mul_start_d;
    logic [WID-1:0]    mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [WID-1:0]    op_a, op_b;
    logic              is_mult, issue, done_mul;
`ifdef MONTEXP_SKIPLZ_EN
    logic              seen1_q, seen1_d;
`endif

    assign busy      = (state_q != StIdle) && (state_q != StDone);
    assign vld       = (state_q == StDone);
    assign r         = r_q;
    assign mul_start = mul_start_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign mul_m     = m_q;

    // Multiplier operand selection for the current step.
    always_comb begin
        op_a = acc_q;
        op_b = acc_q;
        case (state_q)
            StToMont: begin op_a = base_q; op_b = r2_q; end
            StOne:    begin op_a = r2_q;   op_b = One;  end
            StMul:    op_b = xbar_q;
            StFrom:   op_b = One;
            default:  ;
        endcase
    end

    // Sequencer next-state: issue one multiply per step, then consume its result.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        expo_d      = expo_q;
        m_d         = m_q;
        r2_d        = r2_q;
        xbar_d      = xbar_q;
        acc_d       = acc_q;
        r_d         = r_q;
        idx_d       = idx_q;
        wait_d      = wait_q;
        mul_start_d = 1'b0;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
`ifdef MONTEXP_SKIPLZ_EN
        seen1_d     = seen1_q;
`endif
        is_mult  = (state_q == StToMont) || (state_q == StOne) || (state_q == StSqr) ||
                   (state_q == StMul) || (state_q == StFrom);
        issue    = is_mult && !wait_q;
`ifdef MONTEXP_SKIPLZ_EN
        // Squaring 1 (in Montgomery form) is a no-op until a set bit is seen.
        if (state_q == StSqr && !seen1_q) issue = 1'b0;
`endif
        // A result is only taken while a multiply is outstanding.
        done_mul = is_mult && wait_q && mul_vld;

        if (issue) begin
            mul_start_d = 1'b1;
            mul_a_d     = op_a;
            mul_b_d     = op_b;
            wait_d      = 1'b1;
        end
        if (done_mul) wait_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    base_d  = base;
                    expo_d  = expo;
                    m_d     = m;
                    r2_d    = r2;
                    wait_d  = 1'b0;
`ifdef MONTEXP_SKIPLZ_EN
                    seen1_d = 1'b0;
`endif
                    state_d = StToMont;
                end
            end
            StToMont: if (done_mul) begin xbar_d = mul_r; state_d = StOne; end
            StOne: begin
                if (done_mul) begin
                    acc_d   = mul_r;
                    idx_d   = IdxTop;
                    state_d = StSqr;
                end
            end
            StSqr: begin
`ifdef MONTEXP_SKIPLZ_EN
                if (!seen1_q) state_d = expo_q[idx_q] ? StMul : StStep;
`endif
                if (done_mul) begin
                    acc_d   = mul_r;
                    state_d = expo_q[idx_q] ? StMul : StStep;
                end
            end
            StMul: begin
                if (done_mul) begin
                    acc_d   = mul_r;
`ifdef MONTEXP_SKIPLZ_EN
                    seen1_d = 1'b1;
`endif
                    state_d = StStep;
                end
            end
            StStep: begin
                // Test before decrementing so idx never wraps.
                if (idx_q == '0) begin
                    state_d = StFrom;
                end else begin
                    idx_d   = idx_q - 1'b1;
                    state_d = StSqr;
                end
            end
            StFrom: if (done_mul) begin r_d = mul_r; state_d = StDone; end
            StDone: state_d = StIdle;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            base_q      <= '0;
            expo_q      <= '0;
            m_q         <= '0;
            r2_q        <= '0;
            xbar_q      <= '0;
            acc_q       <= '0;
            r_q         <= '0;
            idx_q       <= '0;
            wait_q      <= 1'b0;
            mul_start_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
`ifdef MONTEXP_SKIPLZ_EN
            seen1_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            expo_q      <= expo_d;
            m_q         <= m_d;
            r2_q        <= r2_d;
            xbar_q      <= xbar_d;
            acc_q       <= acc_d;
            r_q         <= r_d;
            idx_q       <= idx_d;
            wait_q      <= wait_d;
            mul_start_q <= mul_start_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
`ifdef MONTEXP_SKIPLZ_EN
            seen1_q     <= seen1_d;
`endif
        end
    end

endmodule

// File: tb/tb_montexp_seq.sv
// Scoreboard bench for montexp_seq with a behavioural Montgomery multiplier.
module tb_montexp_seq;

    localparam int W  = 8;
    localparam int E  = 4;
    localparam int EC = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] base = '0, m = '0, r2 = '0;
    logic [E-1:0] expo = '0;
    logic         busy, vld, mul_start;
    logic [W-1:0] r, mul_a, mul_b, mul_m;
    logic         model_vld = 1'b0, stray_vld = 1'b0;
    logic [W-1:0] mul_r = '0;
    logic         mul_vld;

    assign mul_vld = model_vld | stray_vld;

    montexp_seq #(.WID(W), .EWID(E), .ECNTW(EC)) dut (
        .clk(clk), .rst(rst), .start(start), .base(base), .expo(expo), .m(m), .r2(r2),
        .busy(busy), .vld(vld), .r(r), .mul_start(mul_start), .mul_a(mul_a),
        .mul_b(mul_b), .mul_m(mul_m), .mul_vld(mul_vld), .mul_r(mul_r)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int lat = 1;
    bit stray_en = 1'b0;

    typedef struct {
        int r;
        int nmul;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // a*b*R^-1 mod mm, found by searching for t with t*R == a*b (mod mm).
    function automatic int montmul(input int a, input int b, input int mm);
        int p;
        if (mm <= 0) return 0;
        p = (a * b) % mm;
        for (int t = 0; t < mm; t++) if (((t << W) % mm) == p) return t;
        return 0;
    endfunction

    function automatic int modpow(input int b, input int e, input int mm);
        int acc = 1 % mm;
        for (int i = 0; i < e; i++) acc = (acc * b) % mm;
        return acc;
    endfunction

    function automatic int nmul_exp(input int e);
        int pc = 0;
        int msb = 0;
        for (int i = 0; i < E; i++) if ((e >> i) & 1) begin pc++; msb = i; end
`ifdef MONTEXP_SKIPLZ_EN
        return 3 + pc + msb;
`else
        return 3 + E + pc;
`endif
    endfunction

    // Behavioural multiplier: latency `lat`, checks operands stay put while waiting.
    initial begin
        int a0, b0, m0, res;
        bit held, aborted;
        @(negedge clk);
        forever begin
            if (rst && mul_start) begin
                a0 = int'(mul_a); b0 = int'(mul_b); m0 = int'(mul_m);
                res = montmul(a0, b0, m0);
                held = 1'b1; aborted = 1'b0;
                for (int i = 0; i < lat; i++) begin
                    @(negedge clk);
                    if (!rst) aborted = 1'b1;
                    if (!aborted && (int'(mul_a) != a0 || int'(mul_b) != b0 ||
                                     int'(mul_m) != m0 || mul_start)) held = 1'b0;
                end
                if (!aborted) chk("operand_hold", held, 1);
                model_vld = 1'b1;
                mul_r = W'(res);
                @(negedge clk);
                if (stray_en) begin
                    // Extra pulse lands where the sequencer is not waiting.
                    mul_r = ~W'(res);
                    @(negedge clk);
                end
                model_vld = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
    end

    // Monitor: pops the scoreboard on every vld.
    initial begin
        int mul_cnt = 0;
        bit prev = 1'b0;
        exp_t ex;
        forever begin
            @(negedge clk);
            if (!rst) begin
                mul_cnt = 0;
                prev = 1'b0;
            end else begin
                if (mul_start) mul_cnt++;
                if (vld) begin
                    chk("vld_pulse_width", prev, 0);
                    chk("vld_with_job_pending", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        ex = exp_q.pop_front();
                        chk("result", r, ex.r);
                        chk("mul_count", mul_cnt, ex.nmul);
                    end
                    mul_cnt = 0;
                end
                prev = vld;
            end
        end
    end

    task automatic drive_ops(input int b, input int e, input int mm);
        base = W'(b); expo = E'(e); m = W'(mm); r2 = W'((1 << (2 * W)) % mm);
    endtask

    task automatic issue(input int b, input int e, input int mm, input bit push);
        exp_t ex;
        @(negedge clk);
        drive_ops(b, e, mm);
        start = 1'b1;
        if (push) begin
            ex.r = modpow(b, e, mm);
            ex.nmul = nmul_exp(e);
            exp_q.push_back(ex);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_vld();
        int n = 0;
        while (!vld && n < 1500) begin @(negedge clk); n++; end
        chk("done_in_time", vld, 1);
    endtask

    task automatic run(input int b, input int e, input int mm);
        issue(b, e, mm, 1'b1);
        wait_vld();
        @(negedge clk);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int tgt, seen, n, cnt, mm, b;
        exp_t ex;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_vld", vld, 0);
        chk("rst_r", r, 0);
        chk("rst_mul_start", mul_start, 0);
        chk("rst_mul_a", mul_a, 0);
        chk("rst_mul_b", mul_b, 0);
        chk("rst_mul_m", mul_m, 0);
        rst = 1'b1;

        // Stray mul_vld while idle.
        @(negedge clk); stray_vld = 1'b1;
        @(negedge clk); stray_vld = 1'b0;
        @(negedge clk);
        chk("idle_stray_busy", busy, 0);

        lat = 5;
        run(2, 5, 13);
        lat = 3;
        run(7, 0, 13);

        // Back-to-back: a start during DONE is ignored, the next cycle's is taken.
        lat = 2;
        issue(12, 15, 13, 1'b1);
        wait_vld();
        drive_ops(1, 1, 13);
        start = 1'b1;
        @(negedge clk);
        chk("done_start_ignored", busy, 0);
        drive_ops(5, 7, 13);
        ex.r = modpow(5, 7, 13);
        ex.nmul = nmul_exp(7);
        exp_q.push_back(ex);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_accepted", busy, 1);
        wait_vld();
        @(negedge clk);

        // Start re-pulsed while busy, plus stray mul_vld after every result.
        lat = 4; stray_en = 1'b1;
        issue(3, 9, 13, 1'b1);
        repeat (15) @(negedge clk);
        drive_ops(4, 2, 11);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_start_ignored", busy, 1);
        wait_vld();
        @(negedge clk);

        // Latency sweep on one job.
        lat = 0;  run(6, 11, 13);
        lat = 1;  run(6, 11, 13);
        lat = 40; run(6, 11, 13);
        stray_en = 1'b0;

        // Reset in the middle of the first squaring.
`ifdef MONTEXP_SKIPLZ_EN
        tgt = 4;
`else
        tgt = 3;
`endif
        lat = 10;
        issue(5, 8, 13, 1'b1);
        seen = 0; n = 0;
        while (seen < tgt && n < 500) begin
            @(negedge clk); n++;
            if (mul_start) seen++;
        end
        chk("reached_sqr", seen, tgt);
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_vld", vld, 0);
        chk("abort_r", r, 0);
        chk("abort_mul_start", mul_start, 0);
        chk("abort_mul_a", mul_a, 0);
        chk("abort_mul_b", mul_b, 0);
        chk("abort_mul_m", mul_m, 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        cnt = 0;
        repeat (60) begin @(negedge clk); if (vld) cnt++; end
        chk("aborted_job_vld", cnt, 0);
        lat = 2;
        run(5, 8, 13);

        // Randomised jobs over random odd moduli.
        for (int i = 0; i < 12; i++) begin
            mm = int'($urandom_range(127, 1)) * 2 + 1;
            b = int'($urandom_range(mm - 1, 0));
            lat = int'($urandom_range(6, 0));
            stray_en = 1'($urandom_range(1, 0));
            run(b, int'($urandom_range(15, 0)), mm);
        end
        stray_en = 1'b0;
        repeat (50) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
